// File: rtl/dmem_pkg.sv
// Shared encodings and types for the data-memory responder.
// Load/store codes match the control unit's LOADSIGNAL/STORESIGNAL fields.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LW  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  localparam logic [1:0] STORE_SB = 2'd1;
  localparam logic [1:0] STORE_SH = 2'd2;
  localparam logic [1:0] STORE_SW = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Byte accesses are never misaligned; halves need bit 0 clear, words need both bits clear.
  function automatic logic is_misaligned(input logic       is_write,
                                         input logic [1:0] addr_lo,
                                         input logic [2:0] load_signal,
                                         input logic [1:0] store_signal);
    logic mis;
    mis = (addr_lo != 2'b00);
    if (is_write) begin
      if (store_signal == STORE_SB)      mis = 1'b0;
      else if (store_signal == STORE_SH) mis = addr_lo[0];
    end else begin
      if (load_signal == LOAD_LB || load_signal == LOAD_LBU)      mis = 1'b0;
      else if (load_signal == LOAD_LH || load_signal == LOAD_LHU) mis = addr_lo[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half/word lane out of a memory word and
// sign- or zero-extends it according to the load encoding.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_signal,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  // A half at an odd address is truncated onto its containing half.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (load_signal)
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {24'b0, byte_sel};
      LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data = {16'b0, half_sel};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the READ/WRITE/BUSYWAIT handshake.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN to add the MISALIGNED output.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  input  logic [2:0]  LOADSIGNAL,
  input  logic [1:0]  STORESIGNAL,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        MISALIGNED
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    ls_q;
  logic [1:0]    ss_q;
  logic          write_q;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          start;
  logic          access;
  logic          access_ok;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rd_word;
  logic [31:0]   load_value;
  logic          unused_addr;

  assign req         = READ | WRITE;
  assign start       = (state_q == IDLE) && req;
  assign access      = (state_q == BUSY) && (cnt_q == '0);
  assign idx         = addr_q[AW+1:2];
  assign rd_word     = mem[idx];
  // Address bits above the array wrap and are deliberately ignored.
  assign unused_addr = ^ADDRESS[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis       = is_misaligned(write_q, addr_q[1:0], ls_q, ss_q);
  assign access_ok = !mis;
`else
  assign access_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests held into DONE are ignored; BUSYWAIT is forced low while in reset.
  always_comb begin
    BUSYWAIT = 1'b0;
    case (state_q)
      IDLE:    BUSYWAIT = req & RESET;
      BUSY:    BUSYWAIT = 1'b1;
      default: BUSYWAIT = 1'b0;
    endcase
  end

  // Request fields are captured only on the IDLE->BUSY edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ls_q    <= '0;
      ss_q    <= '0;
      write_q <= 1'b0;
    end else if (start) begin
      cnt_q   <= CNT_INIT;
      addr_q  <= ADDRESS[AW+1:0];
      wdata_q <= WRITEDATA;
      ls_q    <= LOADSIGNAL;
      ss_q    <= STORESIGNAL;
      write_q <= WRITE;
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Narrow stores replicate their lane so the byte enables alone choose the target bytes.
  always_comb begin
    be    = 4'hF;
    wlane = wdata_q;
    case (ss_q)
      STORE_SB: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      STORE_SH: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wlane = wdata_q;
      end
    endcase
  end

  // NOTE: the storage array has no reset; contents survive RESET and only state is cleared.
  always_ff @(posedge CLK) begin
    if (access && write_q && access_ok) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  dmem_load_align u_load_align (
    .word        (rd_word),
    .addr_lo     (addr_q[1:0]),
    .load_signal (ls_q),
    .data        (load_value)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                                   READDATA <= '0;
    else if (access && !write_q && access_ok)     READDATA <= load_value;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) MISALIGNED <= 1'b0;
    else        MISALIGNED <= access && mis;
  end
`endif

endmodule
